// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types, MISR constants and sizing helper for the truth-table sweep engine
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } tt_state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic int tt_words(input int n_in, input int word_w);
        return (1 << n_in) / word_w;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// rtl/tt_sweep_capture_if.sv - truth-table word stream between capture engine and consumer
interface tt_sweep_capture_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] tt_word;
    logic              tt_valid;
    logic              tt_ready;

    modport master (output tt_word, output tt_valid, input tt_ready);
    modport slave  (input tt_word, input tt_valid, output tt_ready);
endinterface

// File: rtl/tt_sweep_misr.sv
// rtl/tt_sweep_misr.sv - 16-bit Galois MISR folding one sampled FUT bit per enabled cycle
module tt_sweep_misr
    import tt_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        bit_in,
    output logic [15:0] sig
);
    logic fb;

    assign fb = sig[15] ^ bit_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end
endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - exhaustive truth-table sweep of a combinational FUT, packed into streamed words
// Optional signature output enabled by defining TT_SWEEP_MISR_EN.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int WORD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [N_IN-1:0]     x_o,
    input  logic                y_i,
    tt_sweep_capture_if.master  tt,
    output logic [N_IN:0]       ones_cnt
`ifdef TT_SWEEP_MISR_EN
    ,
    output logic [15:0]         misr_sig
`endif
);
    localparam int            BIT_W    = $clog2(WORD_W);
    localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'((1 << N_IN) - 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SWEEP = ST_SWEEP;
    localparam logic [1:0] FLUSH = ST_FLUSH;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]        state;
    logic [N_IN:0]     idx;
    logic [WORD_W-1:0] sbuf;
    logic [WORD_W-1:0] sbuf_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic              word_end;
    logic              handshake;
    logic              stall;
    logic              sample;

    assign bit_idx   = idx[BIT_W-1:0];
    assign word_end  = &bit_idx;
    assign handshake = tt.tt_valid && tt.tt_ready;
    // Only a word boundary needs the output register free; other bits land in the shift buffer.
    assign stall     = word_end && tt.tt_valid && !tt.tt_ready;
    assign sample    = (state == SWEEP) && !stall;

    assign busy = (state == SWEEP) || (state == FLUSH);
    assign done = (state == DONE);
    // idx runs one past the table end in FLUSH; pin x_o at the last vector instead of wrapping.
    assign x_o  = idx[N_IN] ? {N_IN{1'b1}} : idx[N_IN-1:0];

    always_comb begin
        sbuf_nxt          = sbuf;
        sbuf_nxt[bit_idx] = y_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            sbuf        <= '0;
            ones_cnt    <= '0;
            tt.tt_word  <= '0;
            tt.tt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SWEEP;
                        idx      <= '0;
                        sbuf     <= '0;
                        ones_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (sample) begin
                        idx      <= idx + 1'b1;
                        sbuf     <= sbuf_nxt;
                        ones_cnt <= ones_cnt + (N_IN+1)'(y_i);
                        if (idx == IDX_LAST) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (handshake) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase

            // A freshly completed word wins over clearing valid on a same-cycle handshake.
            if (sample && word_end) begin
                tt.tt_word  <= sbuf_nxt;
                tt.tt_valid <= 1'b1;
            end else if (handshake) begin
                tt.tt_valid <= 1'b0;
            end
        end
    end

`ifdef TT_SWEEP_MISR_EN
    logic start_ok;

    assign start_ok = (state == IDLE) && start;

    tt_sweep_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .en     (sample),
        .clr    (start_ok),
        .bit_in (y_i),
        .sig    (misr_sig)
    );
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - scoreboard bench for tt_sweep_capture (MISR checks when TT_SWEEP_MISR_EN is defined)
module tb_tt_sweep_capture;
    import tt_sweep_pkg::*;

    localparam int N_IN    = 8;
    localparam int WORD_W  = 16;
    localparam int N_WORDS = tt_words(N_IN, WORD_W);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [N_IN-1:0]   x_o;
    logic              y_i;
    logic [N_IN:0]     ones_cnt;
`ifdef TT_SWEEP_MISR_EN
    logic [15:0]       misr_sig;
`endif

    tt_sweep_capture_if #(.WORD_W(WORD_W)) tt_bus ();

    tt_sweep_capture #(.N_IN(N_IN), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .x_o      (x_o),
        .y_i      (y_i),
        .tt       (tt_bus),
        .ones_cnt (ones_cnt)
`ifdef TT_SWEEP_MISR_EN
        ,
        .misr_sig (misr_sig)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           mode;
    logic [255:0] fut_tbl;
    logic [15:0]  exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    always_comb begin
        case (mode)
            1:       y_i = x_o[0];
            2:       y_i = &x_o;
            3:       y_i = fut_tbl[x_o];
            default: y_i = 1'b0;
        endcase
    end

    function automatic logic fut_bit(input int m, input logic [7:0] v);
        case (m)
            1:       return v[0];
            2:       return v == 8'hFF;
            3:       return fut_tbl[v];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        logic fb;
        fb = s[15] ^ b;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
        check_eq({tag, " x_o"}, x_o, 0);
        check_eq({tag, " tt_word"}, tt_bus.tt_word, 0);
        check_eq({tag, " tt_valid"}, tt_bus.tt_valid, 0);
        check_eq({tag, " ones_cnt"}, ones_cnt, 0);
`ifdef TT_SWEEP_MISR_EN
        check_eq({tag, " misr_sig"}, misr_sig, 0);
`endif
    endtask

    // stall_n: hold ready low from word 0 until x_o has sat at 31 for stall_n stalled edges.
    task automatic sweep(input string tag, input int m, input int stall_n,
                         input int pulse_at, input int abort_at);
        int          t0;
        int          guard;
        int          stall_cnt;
        int          phase;
        int          ones;
        bit          seen31;
        bit          fin;
        logic [15:0] msig;
        logic [15:0] w;
        logic [7:0]  v;

        mode = m;
        ones = 0;
        msig = 16'hFFFF;
        exp_q.delete();
        for (int wi = 0; wi < N_WORDS; wi++) begin
            w = '0;
            for (int b = 0; b < WORD_W; b++) begin
                v    = 8'(wi * WORD_W + b);
                w[b] = fut_bit(m, v);
                ones += int'(w[b]);
                msig = misr_step(msig, w[b]);
            end
            exp_q.push_back(w);
        end

        tt_bus.tt_ready = 1'b1;
        stall_cnt = 0;
        phase     = (stall_n > 0) ? 0 : 2;
        seen31    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " first x_o"}, x_o, 0);
        check_eq({tag, " busy"}, busy, 1);

        fin   = 1'b0;
        guard = 0;
        while (!fin && guard < 2000) begin
            guard++;
            if (abort_at >= 0 && int'(x_o) == abort_at && busy) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_vals({tag, " post-rst"});
                rst = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end else begin
                start = (pulse_at >= 0 && int'(x_o) == pulse_at);
                if (phase == 0 && tt_bus.tt_valid) begin
                    tt_bus.tt_ready = 1'b0;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (x_o == 8'd31) seen31 = 1'b1;
                    if (seen31) begin
                        check_eq({tag, " stall x_o"}, x_o, 31);
                        check_eq({tag, " stall word"}, tt_bus.tt_word, exp_q[0]);
                        if (stall_cnt == stall_n) begin
                            tt_bus.tt_ready = 1'b1;
                            phase = 2;
                        end else begin
                            stall_cnt++;
                        end
                    end
                end
                if (tt_bus.tt_valid && tt_bus.tt_ready) begin
                    if (exp_q.size() > 0) begin
                        check_eq({tag, " word"}, tt_bus.tt_word, exp_q.pop_front());
                    end else begin
                        check_eq({tag, " extra word"}, 1, 0);
                    end
                end
                if (done) begin
                    check_eq({tag, " done latency"}, cyc - t0, 258 + stall_n);
                    check_eq({tag, " busy at done"}, busy, 0);
                    check_eq({tag, " ones_cnt"}, ones_cnt, ones);
                    check_eq({tag, " words left"}, exp_q.size(), 0);
`ifdef TT_SWEEP_MISR_EN
                    check_eq({tag, " misr_sig"}, misr_sig, msig);
`endif
                    fin = 1'b1;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) check_eq({tag, " timeout"}, 1, 0);
        if (abort_at < 0) begin
            check_eq({tag, " done pulse"}, done, 0);
            check_eq({tag, " idle x_o"}, x_o, 0);
            check_eq({tag, " idle ones hold"}, ones_cnt, ones);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tt_bus.tt_ready = 1'b1;
        for (int i = 0; i < 8; i++) fut_tbl[i*32 +: 32] = $urandom;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        sweep("zero",      0, 0,  -1,  -1);
        sweep("alt",       1, 0,  -1,  -1);
        sweep("and",       2, 0,  -1,  -1);
        sweep("stall",     1, 10, -1,  -1);
        sweep("abort",     1, 0,  -1,  100);
        sweep("after_rst", 1, 0,  -1,  -1);
        sweep("restart",   3, 0,  50,  -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
